// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: control bundle layout,
// ALU operation codes and primary opcodes used by the decoder upstream.
package id_ex_stage_pkg;

   localparam int CTRL_W = 16;

   // Bit positions inside the 16-bit control bundle (MSB first as decoded)
   localparam int C_REGDST     = 15;
   localparam int C_REGWRITE   = 14;
   localparam int C_MEMTOREG   = 13;
   localparam int C_JUMP       = 12;
   localparam int C_JAL        = 11;
   localparam int C_MEMREAD    = 10;
   localparam int C_MEMWRITE   = 9;
   localparam int C_BEQ        = 8;
   localparam int C_BNE        = 7;
   localparam int C_ALUSRC     = 6;
   localparam int C_ISSIGNED   = 5;
   localparam int C_ALUOP_MSB  = 4;
   localparam int C_ALUOP_LSB  = 1;
   localparam int C_FLOATOP    = 0;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_R    = 4'd2,
      ALU_OR   = 4'd3,
      ALU_ADDI = 4'd4,
      ALU_AND  = 4'd5,
      ALU_SUB  = 4'd7
   } aluop_e;

   typedef enum logic [5:0] {
      OP_J   = 6'h02,
      OP_R   = 6'h03,
      OP_BNE = 6'h04,
      OP_BEQ = 6'h05,
      OP_JAL = 6'h07,
      OP_LUI = 6'h0f,
      OP_LW  = 6'h12,
      OP_LBU = 6'h22,
      OP_SB  = 6'h28,
      OP_SW  = 6'h2b
   } opcode_e;

   // One-hot control word with only the given bundle bit set
   function automatic logic [CTRL_W-1:0] ctrl_bit(input int idx);
      return CTRL_W'(1) << idx;
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between the decode side (master drives id_*) and the ID/EX register
// (slave drives ex_*). Data is qualified by id_valid / ex_valid; there is no
// back-pressure on this bundle itself -- freezing is signalled separately by
// hold_i (downstream) and stall_o (upstream).
interface id_ex_stage_if #(
   parameter int DATA_W = 32
);
   import id_ex_stage_pkg::*;

   logic [CTRL_W-1:0] id_ctrl;
   logic              id_valid;
   logic [DATA_W-1:0] id_pc4;
   logic [DATA_W-1:0] id_rs_data;
   logic [DATA_W-1:0] id_rt_data;
   logic [DATA_W-1:0] id_imm;
   logic [4:0]        id_rs;
   logic [4:0]        id_rt;
   logic [4:0]        id_rd;
   logic [4:0]        id_shamt;

   logic [CTRL_W-1:0] ex_ctrl;
   logic              ex_valid;
   logic [DATA_W-1:0] ex_pc4;
   logic [DATA_W-1:0] ex_rs_data;
   logic [DATA_W-1:0] ex_rt_data;
   logic [DATA_W-1:0] ex_imm;
   logic [4:0]        ex_rs;
   logic [4:0]        ex_rt;
   logic [4:0]        ex_rd;
   logic [4:0]        ex_shamt;

   modport master (
      output id_ctrl, id_valid, id_pc4, id_rs_data, id_rt_data, id_imm,
             id_rs, id_rt, id_rd, id_shamt,
      input  ex_ctrl, ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
             ex_rs, ex_rt, ex_rd, ex_shamt
   );

   modport slave (
      input  id_ctrl, id_valid, id_pc4, id_rs_data, id_rt_data, id_imm,
             id_rs, id_rt, id_rd, id_shamt,
      output ex_ctrl, ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
             ex_rs, ex_rt, ex_rd, ex_shamt
   );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: decides which source registers the ID instruction
// really reads and compares them with the destination of a load sitting in EX.
module id_ex_stage_hazard_detect
   import id_ex_stage_pkg::*;
(
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              id_valid,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic              ex_valid,
   input  logic              ex_memread,
   input  logic [4:0]        ex_rt,
   output logic              uses_rs,
   output logic              uses_rt,
   output logic              lu
);

   // Jumps carry a target in the rs/rt bit positions, and an all-zero
   // control word is a nop, so neither reads rs. rt is a true source only for
   // R-type, branches and stores.
   always_comb begin
      uses_rs = id_valid & ~id_ctrl[C_JUMP] & ~id_ctrl[C_JAL] & (id_ctrl != '0);
      uses_rt = id_valid & (id_ctrl[C_REGDST] | id_ctrl[C_BEQ] |
                            id_ctrl[C_BNE] | id_ctrl[C_MEMWRITE]);
      lu      = ex_valid & ex_memread & (ex_rt != 5'd0) &
                ((uses_rs & (ex_rt == id_rs)) | (uses_rt & (ex_rt == id_rt)));
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush handling
// (including a flush that arrives while the stage is held) and a saturating
// count of inserted load-use bubbles.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   id_ex_stage_if.slave     bus,
   input  logic             flush_i,
   input  logic             hold_i,
   output logic             stall_o,
   output logic [CNT_W-1:0] stall_cnt
);

   logic [CTRL_W-1:0] ctrl_q;
   logic              valid_q;
   logic [DATA_W-1:0] pc4_q;
   logic [DATA_W-1:0] rs_data_q;
   logic [DATA_W-1:0] rt_data_q;
   logic [DATA_W-1:0] imm_q;
   logic [4:0]        rs_q;
   logic [4:0]        rt_q;
   logic [4:0]        rd_q;
   logic [4:0]        shamt_q;
   logic              pend_flush;
   logic [CNT_W-1:0]  cnt_q;

   logic uses_rs;
   logic uses_rt;
   logic lu;

   id_ex_stage_hazard_detect u_hazard_detect (
      .id_ctrl    (bus.id_ctrl),
      .id_valid   (bus.id_valid),
      .id_rs      (bus.id_rs),
      .id_rt      (bus.id_rt),
      .ex_valid   (valid_q),
      .ex_memread (ctrl_q[C_MEMREAD]),
      .ex_rt      (rt_q),
      .uses_rs    (uses_rs),
      .uses_rt    (uses_rt),
      .lu         (lu)
   );

   // A flush (live or remembered from a hold) kills the ID instruction, so
   // there is nothing to stall for in that cycle.
   always_comb begin
      stall_o = hold_i | (lu & ~flush_i & ~pend_flush);
   end

   // Pipeline register: hold > flush > load-use bubble > normal advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q     <= '0;
         valid_q    <= 1'b0;
         pc4_q      <= '0;
         rs_data_q  <= '0;
         rt_data_q  <= '0;
         imm_q      <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         shamt_q    <= '0;
         pend_flush <= 1'b0;
         cnt_q      <= '0;
      end else if (hold_i) begin
         if (flush_i) begin
            pend_flush <= 1'b1;
         end
      end else if (flush_i || pend_flush || lu) begin
         ctrl_q     <= '0;
         valid_q    <= 1'b0;
         pc4_q      <= '0;
         rs_data_q  <= '0;
         rt_data_q  <= '0;
         imm_q      <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         shamt_q    <= '0;
         pend_flush <= 1'b0;
         if (!flush_i && !pend_flush && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end else begin
         ctrl_q    <= bus.id_ctrl;
         valid_q   <= bus.id_valid;
         pc4_q     <= bus.id_pc4;
         rs_data_q <= bus.id_rs_data;
         rt_data_q <= bus.id_rt_data;
         imm_q     <= bus.id_imm;
         rs_q      <= bus.id_rs;
         rt_q      <= bus.id_rt;
         rd_q      <= bus.id_rd;
         shamt_q   <= bus.id_shamt;
      end
   end

   assign bus.ex_ctrl    = ctrl_q;
   assign bus.ex_valid   = valid_q;
   assign bus.ex_pc4     = pc4_q;
   assign bus.ex_rs_data = rs_data_q;
   assign bus.ex_rt_data = rt_data_q;
   assign bus.ex_imm     = imm_q;
   assign bus.ex_rs      = rs_q;
   assign bus.ex_rt      = rt_q;
   assign bus.ex_rd      = rd_q;
   assign bus.ex_shamt   = shamt_q;
   assign stall_cnt      = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed instruction sequence, expected EX contents
// queued per cycle and compared by an independent monitor process.
module tb_id_ex_stage;
   import id_ex_stage_pkg::*;

   localparam int DATA_W = 32;

   typedef struct packed {
      logic [15:0] ctrl;
      logic        valid;
      logic [31:0] pc4;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
   } ex_t;

   localparam int EX_W = $bits(ex_t);

   localparam int K_LOAD   = 0;
   localparam int K_BUBBLE = 1;
   localparam int K_HOLD   = 2;

   localparam logic [15:0] CTL_LW = ctrl_bit(C_REGWRITE) | ctrl_bit(C_MEMTOREG) |
                                    ctrl_bit(C_MEMREAD) | ctrl_bit(C_ALUSRC);
   localparam logic [15:0] CTL_R  = ctrl_bit(C_REGDST) | ctrl_bit(C_REGWRITE) |
                                    (16'(ALU_R) << C_ALUOP_LSB);
   localparam logic [15:0] CTL_SW = ctrl_bit(C_MEMWRITE) | ctrl_bit(C_ALUSRC);
   localparam logic [15:0] CTL_J  = ctrl_bit(C_JUMP);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush_i = 1'b0;
   logic hold_i = 1'b0;
   logic stall_o, stall_o2;
   logic [15:0] stall_cnt;
   logic [1:0]  stall_cnt2;

   always #5 clk = ~clk;

   id_ex_stage_if #(.DATA_W(DATA_W)) bus ();
   id_ex_stage_if #(.DATA_W(DATA_W)) bus2 ();

   id_ex_stage #(.DATA_W(DATA_W), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .flush_i(flush_i), .hold_i(hold_i),
      .stall_o(stall_o), .stall_cnt(stall_cnt)
   );

   // Narrow-counter copy sees identical stimulus; only its counter is checked
   id_ex_stage #(.DATA_W(DATA_W), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .bus(bus2), .flush_i(flush_i), .hold_i(hold_i),
      .stall_o(stall_o2), .stall_cnt(stall_cnt2)
   );

   assign bus2.id_ctrl    = bus.id_ctrl;
   assign bus2.id_valid   = bus.id_valid;
   assign bus2.id_pc4     = bus.id_pc4;
   assign bus2.id_rs_data = bus.id_rs_data;
   assign bus2.id_rt_data = bus.id_rt_data;
   assign bus2.id_imm     = bus.id_imm;
   assign bus2.id_rs      = bus.id_rs;
   assign bus2.id_rt      = bus.id_rt;
   assign bus2.id_rd      = bus.id_rd;
   assign bus2.id_shamt   = bus.id_shamt;

   ex_t cur_ex;
   assign cur_ex = {bus.ex_ctrl, bus.ex_valid, bus.ex_pc4, bus.ex_rs_data,
                    bus.ex_rt_data, bus.ex_imm, bus.ex_rs, bus.ex_rt,
                    bus.ex_rd, bus.ex_shamt};

   // ---------------- scoreboard state ----------------
   logic [EX_W-1:0] exp_q[$];
   logic [15:0]     cnt_q[$];
   logic            stall_q[$];
   ex_t             last_exp = '0;
   int              n_cmp = 0;
   int              n_fail = 0;
   int              n_step = 0;

   task automatic check(input string name, input logic [199:0] act,
                        input logic [199:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive_idle();
      bus.id_ctrl = '0; bus.id_valid = 1'b0; bus.id_pc4 = '0;
      bus.id_rs_data = '0; bus.id_rt_data = '0; bus.id_imm = '0;
      bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0; bus.id_shamt = '0;
      flush_i = 1'b0; hold_i = 1'b0;
   endtask

   task automatic step(input logic [15:0] ctrl, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic flush, input logic hold,
                       input logic exp_stall, input int kind, input int exp_cnt);
      @(negedge clk);
      n_step++;
      bus.id_ctrl    = ctrl;
      bus.id_valid   = 1'b1;
      bus.id_pc4     = 32'h1000 + 32'(n_step * 4);
      bus.id_rs_data = 32'ha000_0000 | 32'(n_step);
      bus.id_rt_data = 32'hb000_0000 | 32'(n_step);
      bus.id_imm     = 32'h0000_c000 | 32'(n_step);
      bus.id_rs      = rs;
      bus.id_rt      = rt;
      bus.id_rd      = rd;
      bus.id_shamt   = 5'(n_step);
      flush_i        = flush;
      hold_i         = hold;
      if (kind == K_LOAD) begin
         last_exp = '{ctrl, 1'b1, bus.id_pc4, bus.id_rs_data, bus.id_rt_data,
                      bus.id_imm, rs, rt, rd, bus.id_shamt};
      end else if (kind == K_BUBBLE) begin
         last_exp = '0;
      end
      stall_q.push_back(exp_stall);
      exp_q.push_back(last_exp);
      cnt_q.push_back(16'(exp_cnt));
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic            s;
      logic [EX_W-1:0] e;
      logic [15:0]     c;
      forever begin
         @(negedge clk);
         #2;
         if (stall_q.size() > 0) begin
            s = stall_q.pop_front();
            check("stall_o", 200'(stall_o), 200'(s));
         end
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            c = cnt_q.pop_front();
            check("ex_bundle", 200'(cur_ex), 200'(e));
            check("stall_cnt", 200'(stall_cnt), 200'(c));
            check("stall_cnt_w2", 200'(stall_cnt2), 200'((c > 16'd3) ? 16'd3 : c));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      drive_idle();
      #1;
      check("reset_ex", 200'(cur_ex), 200'(0));
      check("reset_cnt", 200'(stall_cnt), 200'(0));
      check("reset_stall", 200'(stall_o), 200'(0));
      @(negedge clk);
      rst_n = 1'b1;

      //   ctrl    rs  rt  rd  fl hd  stall kind      cnt
      step(CTL_LW, 1,  5,  0,  0, 0,  0,    K_LOAD,   0); // LW r5
      step(CTL_R,  5,  6,  7,  0, 0,  1,    K_BUBBLE, 1); // uses r5 -> stall
      step(CTL_R,  5,  6,  7,  0, 0,  0,    K_LOAD,   1); // replayed, enters EX
      step(CTL_LW, 2,  0,  0,  0, 0,  0,    K_LOAD,   1); // LW r0
      step(CTL_R,  0,  0,  1,  0, 0,  0,    K_LOAD,   1); // r0 never hazards
      step(CTL_LW, 1,  5,  0,  0, 0,  0,    K_LOAD,   1); // LW r5
      step(CTL_J,  5,  5,  5,  0, 0,  0,    K_LOAD,   1); // J target bits = 5
      step(CTL_LW, 1,  5,  0,  0, 0,  0,    K_LOAD,   1); // LW r5
      step(CTL_SW, 1,  5,  0,  0, 0,  1,    K_BUBBLE, 2); // store data r5
      step(CTL_SW, 1,  5,  0,  0, 0,  0,    K_LOAD,   2);
      step(CTL_LW, 1,  5,  0,  0, 0,  0,    K_LOAD,   2);
      step(CTL_LW, 5,  5,  0,  0, 0,  1,    K_BUBBLE, 3); // address from r5
      step(CTL_LW, 5,  5,  0,  0, 0,  0,    K_LOAD,   3);
      step(CTL_LW, 3,  5,  0,  0, 0,  0,    K_LOAD,   3); // same rt, no stall
      step(CTL_R,  5,  6,  7,  1, 0,  0,    K_BUBBLE, 3); // lu + flush
      step(CTL_R,  5,  6,  7,  0, 0,  0,    K_LOAD,   3);
      step(CTL_LW, 1,  9,  0,  0, 0,  0,    K_LOAD,   3);
      step(CTL_R,  9,  0,  2,  0, 0,  1,    K_BUBBLE, 4); // 4th bubble
      step(CTL_R,  9,  0,  2,  0, 0,  0,    K_LOAD,   4);
      step(CTL_LW, 1,  4,  0,  0, 0,  0,    K_LOAD,   4);
      step(CTL_R,  4,  6,  3,  0, 1,  1,    K_HOLD,   4); // hold 1
      step(CTL_R,  4,  6,  3,  1, 1,  1,    K_HOLD,   4); // hold 2 + flush
      step(CTL_R,  4,  6,  3,  0, 1,  1,    K_HOLD,   4); // hold 3
      step(CTL_R,  4,  6,  3,  0, 0,  0,    K_BUBBLE, 4); // pending flush
      step(CTL_R,  7,  8,  3,  0, 0,  0,    K_LOAD,   4);
      step(CTL_LW, 1,  3,  0,  0, 0,  0,    K_LOAD,   4);
      step(CTL_R,  3,  8,  2,  1, 1,  1,    K_HOLD,   4); // arm pending flush

      // Asynchronous reset between edges while EX holds a valid load
      @(posedge clk);
      #3;
      @(negedge clk);
      #3;
      hold_i = 1'b0;
      flush_i = 1'b0;
      rst_n = 1'b0;
      #1;
      check("async_rst_ex", 200'(cur_ex), 200'(0));
      check("async_rst_cnt", 200'(stall_cnt), 200'(0));
      check("async_rst_cnt_w2", 200'(stall_cnt2), 200'(0));
      check("async_rst_stall", 200'(stall_o), 200'(0));
      @(negedge clk);
      drive_idle();
      rst_n = 1'b1;
      last_exp = '0;

      step(CTL_R,  3,  8,  2,  0, 0,  0,    K_LOAD,   0); // pending flush gone
      step(CTL_R,  1,  2,  3,  1, 0,  0,    K_BUBBLE, 0); // plain flush
      step(CTL_R,  1,  2,  3,  0, 0,  0,    K_LOAD,   0);

      // Drain with a bounded wait
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      #3;
      n_cmp++;
      if (exp_q.size() != 0 || stall_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: time limit reached, required finish before limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register sitting directly downstream of the opcode control decoder.
- Each cycle it captures the decoder's control bundle plus the decoded operands and register specifiers.
- Detects load-use hazards against the instruction currently in EX and inserts one-cycle bubbles.
- Honours branch/jump flushes and downstream hold (memory wait); keeps a saturating stall counter for performance monitoring.

Parameters:
- DATA_W, 32, operand/PC/immediate width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_ctrl  in  16  {RegDst,RegWrite,MemtoReg,Jump,JmpandLink,MemRead,MemWrite,BranchEqual,BranchnotEqual,ALUSrc,Issigned,ALUop[3:0],floatop}
- id_valid  in  1  ID holds a real instruction
- id_pc4  in  DATA_W  PC+4 of ID instruction
- id_rs_data, id_rt_data  in  DATA_W  register file read data
- id_imm  in  DATA_W  extended immediate
- id_rs, id_rt, id_rd  in  5  register specifiers
- id_shamt  in  5  shift amount
- flush_i  in  1  branch/jump taken; kill ID instruction
- hold_i  in  1  downstream freeze
- ex_ctrl  out  16  registered control bundle
- ex_valid  out  1  registered valid
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered data
- ex_rs, ex_rt, ex_rd, ex_shamt  out  5  registered fields
- stall_o  out  1  combinational: freeze PC and IF/ID this cycle
- stall_cnt  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset (rst_n=0, async): all registered outputs 0; pending-flush bit 0; stall_cnt 0.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- Source-use qualification, from id_ctrl:
  - uses_rs = id_valid & ~Jump & ~JmpandLink & (id_ctrl != 0)
  - uses_rt = id_valid & (RegDst | BranchEqual | BranchnotEqual | MemWrite)
- Load-use hazard (lu) = ex_valid & ex_MemRead & ex_rt != 0 & ((uses_rs & ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)).
- Per-edge priority:
  1. hold_i=1: all ex_* hold; stall_o=1; if flush_i, set pending-flush; no counter change.
  2. flush_i=1 or pending-flush=1: load bubble; clear pending-flush; stall_o=0 (flush overrides lu).
  3. lu=1: load bubble; stall_o=1; stall_cnt += 1, saturating at all-ones.
  4. Otherwise: load ID fields; ex_valid = id_valid.
- Bubble: ex_ctrl=0, ex_valid=0, all data/field outputs 0.
- stall_o = hold_i | (lu & ~flush_i & ~pending-flush).
- lu lasts at most 1 cycle, because the bubble clears ex_MemRead.
- Back-to-back loads to the same rt each stall only once.
- Reset mid-stall: all state cleared immediately; stall_o falls to 0 on the next evaluation.

Decomposition:
- Shared package:
  - ctrl bundle bit-index constants
  - ALUop encodings (ADD=0, R=2, OR=3, ADDI=4, AND=5, SUB=7)
  - opcode constants (LW=6'h12, LBU=6'h22, SB=6'h28, SW=6'h2b, R=6'h3, BEQ=6'h5, BNE=6'h4, J=6'h2, JAL=6'h7, LUI=6'hf)
  - CTRL_W=16
- Sub-module: hazard_detect (combinational: uses_rs, uses_rt, lu), instantiated once.

Test Plan:
- Reset asserted mid-run with ex_valid=1 -> all outputs 0 asynchronously, stall_cnt=0.
- LW rt=5 in EX, then R-type with rs=5 in ID -> stall_o=1 for one cycle; bubble in EX (ex_valid=0, ex_ctrl=0); R-type enters EX next cycle; stall_cnt=1.
- LW rt=0 in EX, R-type with rs=0 in ID -> no stall. J in ID, LW rt=5 in EX, J target field matching 5 -> no stall.
- lu and flush_i in the same cycle -> stall_o=0, bubble, stall_cnt unchanged.
- hold_i=1 for 3 cycles with flush_i pulsed in cycle 2 -> ex_* frozen; first cycle after hold releases produces a bubble.
- CNT_W=2, four load-use events -> stall_cnt reads 1, 2, 3, 3 (saturates).
